// File: rtl/router_pkg.sv
// Shared types for the router receive path.
//   BYTE_W     : width of one reassembled byte
//   rx_entry_t : one FIFO entry {last, err, data}
//   rx_state_e : receiver FSM states
package router_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef struct packed {
        logic              last;
        logic              err;
        logic [BYTE_W-1:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        RESYNC   = 2'd0,
        IDLE     = 2'd1,
        RECV     = 2'd2,
        EOP_PEND = 2'd3
    } rx_state_e;

endpackage

// File: rtl/router_rx_fifo.sv
// Synchronous first-word-visible FIFO for receiver entries.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push_i     : write wdata_i (accepted when not full, or when popping on the same edge)
//   wdata_i    : entry to write
//   pop_i      : remove head entry (ignored when empty)
//   rdata_o    : head entry, valid while empty_o is low
//   full_o     : no free slot
//   empty_o    : no stored entry
module router_rx_fifo
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter type         T     = rx_entry_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] PtrOne = 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    T              mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot on the same edge, so a full FIFO still accepts.
    assign do_push = push_i && (!full_o || do_pop);

    assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/router_rx_deserializer.sv
// Per-port receiver: reassembles a bit-serial (LSB first) router output into bytes,
// tags each byte with end-of-packet and error flags, and buffers them for a
// valid/ready consumer. The router cannot be stalled, so overflow drops entries.
//   clk, reset          : clock, asynchronous active-high reset
//   dout                : serial data bit
//   valido_n            : active-low, dout carries a valid bit
//   frameo_n            : active-low frame, rises with the last valid bit
//   m_valid/m_ready     : byte stream handshake
//   m_data/m_last/m_err : head entry (zero while m_valid is low)
//   busy                : receiving a frame or owing a terminator
//   overflow            : sticky, an entry was dropped since reset
//   pkt_count           : terminating entries written (saturating)
//   drop_count          : entries dropped on a full FIFO (saturating)
module router_rx_deserializer
    import router_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dout,
    input  logic             valido_n,
    input  logic             frameo_n,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             m_err,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [CNT_W-1:0] CntOne = 1;

    rx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              pkt_err_q, pkt_err_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;

    // Receive datapath view: in IDLE a starting frame begins from a clean slate.
    logic              rx_active;
    logic [BYTE_W-1:0] cur_shift;
    logic [2:0]        cur_cnt;
    logic              cur_err;
    logic [BYTE_W-1:0] new_byte;

    logic              push_req;
    logic              push_term;
    rx_entry_t         push_entry;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              can_write;
    rx_entry_t         head;

    assign fifo_pop  = m_valid && m_ready;
    assign can_write = !fifo_full || fifo_pop;
    assign fifo_push = push_req && can_write;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        pkt_err_d    = pkt_err_q;
        overflow_d   = overflow_q;
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        rx_active    = 1'b0;
        push_req     = 1'b0;
        push_term    = 1'b0;
        push_entry   = '0;
        cur_shift    = shift_q;
        cur_cnt      = bit_cnt_q;
        cur_err      = pkt_err_q;
        new_byte     = '0;

        case (state_q)
            RESYNC: begin
                if (frameo_n) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!frameo_n) begin
                    state_d   = RECV;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    pkt_err_d = 1'b0;
                    cur_shift = '0;
                    cur_cnt   = '0;
                    cur_err   = 1'b0;
                    rx_active = 1'b1;
                end
            end
            RECV: begin
                rx_active = 1'b1;
            end
            EOP_PEND: begin
                // Serial input is ignored here; a frame already running on exit is skipped.
                if (can_write) begin
                    push_req   = 1'b1;
                    push_term  = 1'b1;
                    push_entry = '{last: 1'b1, err: 1'b1, data: '0};
                    state_d    = frameo_n ? IDLE : RESYNC;
                end
            end
            default: begin
                state_d = RESYNC;
            end
        endcase

        if (rx_active) begin
            new_byte          = cur_shift;
            new_byte[cur_cnt] = dout;
            if (!valido_n) begin
                if (frameo_n) begin
                    // Last bit: a short final byte is flagged as an error.
                    push_req   = 1'b1;
                    push_term  = 1'b1;
                    push_entry = '{last: 1'b1, err: (cur_cnt == 3'd7) ? cur_err : 1'b1,
                                   data: new_byte};
                    state_d    = IDLE;
                end else if (cur_cnt == 3'd7) begin
                    push_req   = 1'b1;
                    push_entry = '{last: 1'b0, err: cur_err, data: new_byte};
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                end else begin
                    shift_d   = new_byte;
                    bit_cnt_d = cur_cnt + 3'd1;
                end
            end else if (frameo_n) begin
                // Frame ended without a final valid bit: abort, partial bits discarded.
                push_req   = 1'b1;
                push_term  = 1'b1;
                push_entry = '{last: 1'b1, err: 1'b1, data: '0};
                state_d    = IDLE;
            end
        end

        if (push_req && !can_write) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + CntOne;
            end
            if (push_term) begin
                // Terminator still owed; an error terminator replaces it later.
                state_d = EOP_PEND;
            end else begin
                pkt_err_d = 1'b1;
            end
        end else if (push_req && push_term) begin
            if (pkt_count_q != '1) begin
                pkt_count_d = pkt_count_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RESYNC;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            pkt_err_q    <= 1'b0;
            overflow_q   <= 1'b0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            pkt_err_q    <= pkt_err_d;
            overflow_q   <= overflow_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    router_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rx_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head fields are masked so nothing stale is visible while empty.
    assign m_valid    = !fifo_empty;
    assign m_data     = m_valid ? head.data : '0;
    assign m_last     = m_valid ? head.last : 1'b0;
    assign m_err      = m_valid ? head.err : 1'b0;
    assign busy       = (state_q == RECV) || (state_q == EOP_PEND);
    assign overflow   = overflow_q;
    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_router_rx_deserializer.sv
// Directed self-checking bench for router_rx_deserializer (FIFO depth 4).
module tb_router_rx_deserializer;

    localparam int unsigned Depth = 4;
    localparam int unsigned CntW  = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            dout;
    logic            valido_n;
    logic            frameo_n;
    logic            m_valid;
    logic            m_ready;
    logic [7:0]      m_data;
    logic            m_last;
    logic            m_err;
    logic            busy;
    logic            overflow;
    logic [CntW-1:0] pkt_count;
    logic [CntW-1:0] drop_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Entries as {last, err, data}.
    logic [9:0] popped[$];
    logic [9:0] expected[$];

    router_rx_deserializer #(
        .FIFO_DEPTH (Depth),
        .CNT_W      (CntW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dout       (dout),
        .valido_n   (valido_n),
        .frameo_n   (frameo_n),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_err      (m_err),
        .busy       (busy),
        .overflow   (overflow),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the negedge view is what the next edge samples.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            popped.push_back({m_last, m_err, m_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v_n, input logic f_n, input logic d, input logic rdy);
        @(posedge clk);
        #1;
        valido_n = v_n;
        frameo_n = f_n;
        dout     = d;
        m_ready  = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, 1'b0, rdy);
        end
    endtask

    // Sends n bits LSB first; frameo_n rises on the last bit when term is set,
    // otherwise the trailing idle cycle aborts the frame.
    task automatic send_bits(input logic [63:0] bits, input int n, input logic term,
                             input logic rdy, input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    drive(1'b1, 1'b0, 1'b0, rdy);
                end
            end
            drive(1'b0, term && (i == n - 1), bits[i], rdy);
        end
        drive(1'b1, 1'b1, 1'b0, rdy);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        valido_n = 1'b1;
        frameo_n = 1'b1;
        dout     = 1'b0;
        m_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        popped.delete();
        expected.delete();
    endtask

    task automatic compare_stream(input string tag);
        logic [31:0] got;
        check($sformatf("%s_count", tag), popped.size(), expected.size());
        for (int i = 0; i < expected.size(); i++) begin
            got = (i < popped.size()) ? {22'd0, popped[i]} : 32'hdead_beef;
            check($sformatf("%s_entry%0d", tag, i), got, {22'd0, expected[i]});
        end
        popped.delete();
        expected.delete();
    endtask

    initial begin
        reset    = 1'b1;
        valido_n = 1'b1;
        frameo_n = 1'b1;
        dout     = 1'b0;
        m_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2, 1'b0);

        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_err", m_err, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_drop_count", drop_count, 0);

        // Two clean bytes.
        apply_reset();
        send_bits(64'h3CA5, 16, 1'b1, 1'b1, -1, 0);
        idle(4, 1'b1);
        expected.push_back(10'h0A5);
        expected.push_back(10'h23C);
        compare_stream("t1");
        check("t1_pkt_count", pkt_count, 1);
        check("t1_busy", busy, 0);

        // Same packet with an idle gap mid-byte.
        apply_reset();
        send_bits(64'h3CA5, 16, 1'b1, 1'b1, 4, 3);
        idle(4, 1'b1);
        expected.push_back(10'h0A5);
        expected.push_back(10'h23C);
        compare_stream("t2");
        check("t2_pkt_count", pkt_count, 1);

        // 11 bits: short final byte 101b -> 0x05 with error.
        apply_reset();
        send_bits(64'h5FF, 11, 1'b1, 1'b1, -1, 0);
        idle(4, 1'b1);
        expected.push_back(10'h0FF);
        expected.push_back(10'h305);
        compare_stream("t3");
        check("t3_pkt_count", pkt_count, 1);

        // Overflow: 6 bytes into depth 4 with no consumer.
        apply_reset();
        send_bits(64'h6655_4433_2211, 48, 1'b1, 1'b0, -1, 0);
        idle(2, 1'b0);
        check("t4_drop_count", drop_count, 2);
        check("t4_overflow", overflow, 1);
        check("t4_busy_pend", busy, 1);
        check("t4_m_valid", m_valid, 1);
        check("t4_pkt_count_pend", pkt_count, 0);
        idle(8, 1'b1);
        expected.push_back(10'h011);
        expected.push_back(10'h022);
        expected.push_back(10'h033);
        expected.push_back(10'h044);
        expected.push_back(10'h300);
        compare_stream("t4");
        check("t4_pkt_count", pkt_count, 1);
        check("t4_busy_after", busy, 0);

        // Full FIFO, consumer ready on the edge the 5th byte completes.
        apply_reset();
        begin
            logic [47:0] bits5;
            bits5 = 48'h7EC3_1824_4281;
            for (int i = 0; i < 48; i++) begin
                drive(1'b0, (i == 47), bits5[i], (i >= 39));
            end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(8, 1'b1);
        expected.push_back(10'h081);
        expected.push_back(10'h042);
        expected.push_back(10'h024);
        expected.push_back(10'h018);
        expected.push_back(10'h0C3);
        expected.push_back(10'h27E);
        compare_stream("t5");
        check("t5_drop_count", drop_count, 0);
        check("t5_overflow", overflow, 0);
        check("t5_pkt_count", pkt_count, 1);

        // Reset mid-frame, released with the frame still active.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("t6_m_valid", m_valid, 0);
        check("t6_m_data", m_data, 0);
        check("t6_busy", busy, 0);
        check("t6_pkt_count", pkt_count, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        popped.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        idle(4, 1'b1);
        compare_stream("t6_ignored");
        check("t6_pkt_count_ignored", pkt_count, 0);
        send_bits(64'h3CA5, 16, 1'b1, 1'b1, -1, 0);
        idle(4, 1'b1);
        expected.push_back(10'h0A5);
        expected.push_back(10'h23C);
        compare_stream("t6_next");
        check("t6_pkt_count_next", pkt_count, 1);

        // Abort after one full byte.
        apply_reset();
        send_bits(64'h5A, 8, 1'b0, 1'b1, -1, 0);
        idle(4, 1'b1);
        expected.push_back(10'h05A);
        expected.push_back(10'h300);
        compare_stream("t7");
        check("t7_pkt_count", pkt_count, 1);
        check("t7_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
